pixel_analyzer: RTL and testbench

//  Datapath stage driven by the 8x8 scan controller. It consumes x, y, stage, analyze_en and valid.
//  For each centre pixel it fetches 4 neighbours from a 10x10 zero-padded image memory,
//  one per stage, and computes the gradient |U-D|+|L-R|.
//  Per frame it accumulates the edge count and the maximum gradient with its coordinate.
//  It reports the frame result one cycle after the controller's valid.

---
 rtl/pixel_analyzer_pkg.sv | 39 +++
 rtl/pixel_analyzer_grad_calc.sv | 32 +++
 rtl/pixel_analyzer.sv | 204 ++++++++++++++++++++
 tb/tb_pixel_analyzer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_analyzer_pkg.sv
// Shared definitions for the pixel analyzer datapath.
//   IMG_W             : row pitch of the zero-padded 10x10 image memory
//   IDLE/ACC/REPORT   : frame accumulation FSM state encodings
//   ST_UP..ST_RIGHT   : neighbour selected by the controller's stage index
//   calcAddr()        : image address of the neighbour picked by stage
package pixel_analyzer_pkg;

  localparam int unsigned IMG_W = 10;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACC    = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  localparam logic [1:0] ST_UP    = 2'd0;
  localparam logic [1:0] ST_DOWN  = 2'd1;
  localparam logic [1:0] ST_LEFT  = 2'd2;
  localparam logic [1:0] ST_RIGHT = 2'd3;

  // The largest legal address is 9*10+8 = 98, so 7-bit arithmetic never
  // wraps for centre pixels 1..8. Out-of-range x/y only occur while the
  // address is a don't-care.
  function automatic logic [6:0] calcAddr(input logic [3:0] x,
                                          input logic [3:0] y,
                                          input logic [1:0] stage);
    logic [6:0] row;
    logic [6:0] col;
    row = {3'd0, x};
    col = {3'd0, y};
    case (stage)
      ST_UP:    row = row - 7'd1;
      ST_DOWN:  row = row + 7'd1;
      ST_LEFT:  col = col - 7'd1;
      ST_RIGHT: col = col + 7'd1;
      default:  col = col + 7'd1;
    endcase
    return row * 7'(IMG_W) + col;
  endfunction

endpackage

// File: rtl/pixel_analyzer_grad_calc.sv
// Combinational gradient for one centre pixel: grad = |U-D| + |L-R|.
// Ports:
//   up_i, down_i, left_i, right_i : neighbour pixel values (DW bits)
//   grad_o                        : gradient, DW+1 bits (max 2*(2^DW-1))
//   isEdge_o                      : grad_o >= TH
module grad_calc
  import pixel_analyzer_pkg::*;
#(
  parameter int DW = 8,
  parameter int TH = 64
) (
  input  logic [DW-1:0] up_i,
  input  logic [DW-1:0] down_i,
  input  logic [DW-1:0] left_i,
  input  logic [DW-1:0] right_i,
  output logic [DW:0]   grad_o,
  output logic          isEdge_o
);

  logic [DW-1:0] diffV;
  logic [DW-1:0] diffH;

  // Absolute differences are formed by ordering the operands first, so the
  // subtraction never underflows and the sum needs only one extra bit.
  always_comb begin
    diffV    = (up_i >= down_i) ? (up_i - down_i) : (down_i - up_i);
    diffH    = (left_i >= right_i) ? (left_i - right_i) : (right_i - left_i);
    grad_o   = {1'b0, diffV} + {1'b0, diffH};
    isEdge_o = (grad_o >= (DW+1)'(TH));
  end

endmodule

// File: rtl/pixel_analyzer.sv
// Per-frame edge statistics for an 8x8 image scanned by the scan controller.
// For each centre pixel, four neighbours are read from a zero-padded 10x10
// memory (one per PROCESS stage). The gradient is accumulated on the
// ANALYZE cycle, and the frame result is published one cycle after the
// controller's DONE (ctrl_valid).
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   busy, x, y, stage      : controller scan position and neighbour index
//   analyze_en, ctrl_valid : controller ANALYZE / DONE cycles
//   mem_addr, mem_rdata    : image read port (combinational address, 1-cycle data)
//   edge_cnt               : edge count of the last frame
//   max_grad, max_x, max_y : largest gradient of the last frame and its position
//   grad_sum               : sum of all gradients (only with PIXEL_ANALYZER_SUM_EN)
//   result_valid           : one-cycle pulse when the outputs update
// Configuration macro: PIXEL_ANALYZER_SUM_EN builds the gradient-sum
// accumulator. Without it, grad_sum is tied to 0.
module pixel_analyzer
  import pixel_analyzer_pkg::*;
#(
  parameter int DW = 8,
  parameter int TH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          busy,
  input  logic [3:0]    x,
  input  logic [3:0]    y,
  input  logic [1:0]    stage,
  input  logic          analyze_en,
  input  logic          ctrl_valid,
  output logic [6:0]    mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [6:0]    edge_cnt,
  output logic [DW:0]   max_grad,
  output logic [3:0]    max_x,
  output logic [3:0]    max_y,
  output logic [14:0]   grad_sum,
  output logic          result_valid
);

  logic          fetch;
  logic          fetchDly_q;
  logic [1:0]    stageDly_q;
  logic [DW-1:0] up_q;
  logic [DW-1:0] down_q;
  logic [DW-1:0] left_q;
  logic [DW:0]   grad;
  logic          isEdge;
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          accLoad;
  logic          accAdd;
  logic          toReport;
  logic [6:0]    edgeAcc_q;
  logic [DW:0]   maxAcc_q;
  logic [3:0]    maxX_q;
  logic [3:0]    maxY_q;
  logic [6:0]    edgeCnt_q;
  logic [DW:0]   maxGrad_q;
  logic [3:0]    maxXOut_q;
  logic [3:0]    maxYOut_q;
  logic          resultValid_q;

  assign fetch    = busy & ~analyze_en & ~ctrl_valid;
  assign mem_addr = calcAddr(x, y, stage);

  // Read data returns one cycle after its address, so the stage is delayed
  // alongside fetch to steer the data into the right neighbour register.
  // The right neighbour lands in the ANALYZE cycle and feeds grad_calc
  // directly from mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchDly_q <= 1'b0;
      stageDly_q <= 2'd0;
      up_q       <= '0;
      down_q     <= '0;
      left_q     <= '0;
    end else begin
      fetchDly_q <= fetch;
      stageDly_q <= stage;
      if (fetchDly_q) begin
        case (stageDly_q)
          ST_UP:   up_q   <= mem_rdata;
          ST_DOWN: down_q <= mem_rdata;
          ST_LEFT: left_q <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

  grad_calc #(
    .DW (DW),
    .TH (TH)
  ) u_gradCalc (
    .up_i     (up_q),
    .down_i   (down_q),
    .left_i   (left_q),
    .right_i  (mem_rdata),
    .grad_o   (grad),
    .isEdge_o (isEdge)
  );

  // A DONE cycle takes priority over a coincident ANALYZE cycle. In that
  // case the pixel is dropped rather than folded into the closing frame.
  assign accLoad  = (state_q == IDLE) & analyze_en & ~ctrl_valid;
  assign accAdd   = (state_q == ACC) & analyze_en & ~ctrl_valid;
  assign toReport = (state_q == ACC) & ctrl_valid;

  // IDLE waits for the first pixel, ACC folds in the rest, and REPORT is
  // the single cycle in which the new frame result is presented.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accLoad) state_d = ACC;
      ACC:     if (toReport) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first pixel of a frame seeds the running maximum unconditionally.
  // Later pixels replace it only when strictly larger, so the earliest
  // pixel in scan order keeps a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      edgeAcc_q <= '0;
      maxAcc_q  <= '0;
      maxX_q    <= '0;
      maxY_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accLoad) begin
        edgeAcc_q <= 7'(isEdge);
        maxAcc_q  <= grad;
        maxX_q    <= x;
        maxY_q    <= y;
      end else if (accAdd) begin
        edgeAcc_q <= edgeAcc_q + 7'(isEdge);
        if (grad > maxAcc_q) begin
          maxAcc_q <= grad;
          maxX_q   <= x;
          maxY_q   <= y;
        end
      end
    end
  end

  // The result registers load as the FSM enters REPORT, so the outputs and
  // the result_valid pulse appear together one cycle after DONE. The
  // outputs then hold until the next frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edgeCnt_q     <= '0;
      maxGrad_q     <= '0;
      maxXOut_q     <= '0;
      maxYOut_q     <= '0;
      resultValid_q <= 1'b0;
    end else begin
      resultValid_q <= toReport;
      if (toReport) begin
        edgeCnt_q <= edgeAcc_q;
        maxGrad_q <= maxAcc_q;
        maxXOut_q <= maxX_q;
        maxYOut_q <= maxY_q;
      end
    end
  end

  assign edge_cnt     = edgeCnt_q;
  assign max_grad     = maxGrad_q;
  assign max_x        = maxXOut_q;
  assign max_y        = maxYOut_q;
  assign result_valid = resultValid_q;

`ifdef PIXEL_ANALYZER_SUM_EN
  logic [14:0] sumAcc_q;
  logic [14:0] gradSum_q;

  // The gradient sum follows the same load/add/report timing as the edge
  // count. 64 * 510 fits in 15 bits, so the sum cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sumAcc_q  <= '0;
      gradSum_q <= '0;
    end else begin
      if (accLoad) begin
        sumAcc_q <= 15'(grad);
      end else if (accAdd) begin
        sumAcc_q <= sumAcc_q + 15'(grad);
      end
      if (toReport) begin
        gradSum_q <= sumAcc_q;
      end
    end
  end

  assign grad_sum = gradSum_q;
`else
  assign grad_sum = '0;
`endif

endmodule

// File: tb/tb_pixel_analyzer.sv
// Self-checking bench for pixel_analyzer. It plays the 8x8 scan controller
// (4 PROCESS cycles + 1 ANALYZE cycle per pixel, then DONE) against a
// behavioural image memory. Each reported frame is compared with statistics
// computed directly from the padded image. Honours PIXEL_ANALYZER_SUM_EN
// when predicting grad_sum.
module tb_pixel_analyzer;

  localparam int DW = 8;
  localparam int TH = 64;
  localparam int W  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [3:0]  x;
  logic [3:0]  y;
  logic [1:0]  stage;
  logic        analyze_en;
  logic        ctrl_valid;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_rdata = 8'd0;
  logic [6:0]  edge_cnt;
  logic [8:0]  max_grad;
  logic [3:0]  max_x;
  logic [3:0]  max_y;
  logic [14:0] grad_sum;
  logic        result_valid;

  int img[0:99];
  int checks = 0;
  int errors = 0;
  int expEdge, expMax, expMaxX, expMaxY, expSum;

  pixel_analyzer #(.DW(DW), .TH(TH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .busy         (busy),
    .x            (x),
    .y            (y),
    .stage        (stage),
    .analyze_en   (analyze_en),
    .ctrl_valid   (ctrl_valid),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .edge_cnt     (edge_cnt),
    .max_grad     (max_grad),
    .max_x        (max_x),
    .max_y        (max_y),
    .grad_sum     (grad_sum),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read image memory with one cycle of latency
  always @(posedge clk) begin
    mem_rdata <= (mem_addr < 7'd100) ? 8'(img[mem_addr]) : 8'd0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic b, input int px, input int py,
                               input int st, input logic an, input logic cv);
    busy       = b;
    x          = 4'(px);
    y          = 4'(py);
    stage      = 2'(st);
    analyze_en = an;
    ctrl_valid = cv;
    @(posedge clk);
    #1;
  endtask

  function automatic int absDiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Frame statistics straight from the padded image. Scanning in order and
  // replacing only on a strictly larger gradient keeps the first maximum.
  task automatic computeModel();
    int g;
    expEdge = 0;
    expMax  = -1;
    expMaxX = 0;
    expMaxY = 0;
    expSum  = 0;
    for (int r = 1; r <= 8; r++) begin
      for (int c = 1; c <= 8; c++) begin
        g = absDiff(img[(r-1)*W+c], img[(r+1)*W+c]) +
            absDiff(img[r*W+c-1], img[r*W+c+1]);
        if (g >= TH) expEdge++;
        if (g > expMax) begin
          expMax  = g;
          expMaxX = r;
          expMaxY = c;
        end
        expSum += g;
      end
    end
  endtask

  task automatic clearImage();
    for (int i = 0; i < 100; i++) img[i] = 0;
  endtask

  task automatic randomImage();
    clearImage();
    for (int r = 1; r <= 8; r++)
      for (int c = 1; c <= 8; c++)
        img[r*W+c] = int'($urandom_range(0, 255));
  endtask

  task automatic runPixels(input int n);
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < 4; s++) applyStimulus(1'b1, i/8 + 1, i%8 + 1, s, 1'b0, 1'b0);
      applyStimulus(1'b1, i/8 + 1, i%8 + 1, 3, 1'b1, 1'b0);
    end
  endtask

  task automatic runFrame(input string name);
    int expS;
    computeModel();
`ifdef PIXEL_ANALYZER_SUM_EN
    expS = expSum;
`else
    expS = 0;
`endif
    runPixels(64);
    checkOutput({name, " rv_before_done"}, 32'(result_valid), 0);
    applyStimulus(1'b0, 8, 8, 3, 1'b0, 1'b1);
    checkOutput({name, " rv_pulse"}, 32'(result_valid), 1);
    checkOutput({name, " edge_cnt"}, 32'(edge_cnt), expEdge);
    checkOutput({name, " max_grad"}, 32'(max_grad), expMax);
    checkOutput({name, " max_x"}, 32'(max_x), expMaxX);
    checkOutput({name, " max_y"}, 32'(max_y), expMaxY);
    checkOutput({name, " grad_sum"}, 32'(grad_sum), expS);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    checkOutput({name, " rv_drop"}, 32'(result_valid), 0);
    checkOutput({name, " edge_cnt_hold"}, 32'(edge_cnt), expEdge);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " edge_cnt"}, 32'(edge_cnt), 0);
    checkOutput({name, " max_grad"}, 32'(max_grad), 0);
    checkOutput({name, " max_x"}, 32'(max_x), 0);
    checkOutput({name, " max_y"}, 32'(max_y), 0);
    checkOutput({name, " grad_sum"}, 32'(grad_sum), 0);
    checkOutput({name, " result_valid"}, 32'(result_valid), 0);
  endtask

  initial begin
    int expAddr[4];
    int px, py, ps, r, c;
    expAddr = '{8, 28, 17, 19};

    // Power-on reset
    clearImage();
    rst_n = 1'b0;
    busy = 1'b0; x = 4'd0; y = 4'd0; stage = 2'd0;
    analyze_en = 1'b0; ctrl_valid = 1'b0;
    #1;
    checkAllZero("por");
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Single bright pixel: four neighbours tie at 200, earliest wins
    clearImage();
    img[4*W+5] = 200;
    runFrame("single");
    checkOutput("single exact_edge", 32'(edge_cnt), 4);
    checkOutput("single exact_max", 32'(max_grad), 200);
    checkOutput("single exact_x", 32'(max_x), 3);
    checkOutput("single exact_y", 32'(max_y), 5);
`ifdef PIXEL_ANALYZER_SUM_EN
    checkOutput("single exact_sum", 32'(grad_sum), 800);
`else
    checkOutput("single exact_sum", 32'(grad_sum), 0);
`endif

    // Address generation at the right edge, then at random positions
    for (int s = 0; s < 4; s++) begin
      busy = 1'b1; x = 4'd1; y = 4'd8; stage = 2'(s);
      #1;
      checkOutput($sformatf("addr x1y8 stage%0d", s), 32'(mem_addr), expAddr[s]);
    end
    for (int k = 0; k < 6; k++) begin
      px = int'($urandom_range(1, 8));
      py = int'($urandom_range(1, 8));
      ps = int'($urandom_range(0, 3));
      r = px + ((ps == 0) ? -1 : (ps == 1) ? 1 : 0);
      c = py + ((ps == 2) ? -1 : (ps == 3) ? 1 : 0);
      x = 4'(px); y = 4'(py); stage = 2'(ps);
      #1;
      checkOutput($sformatf("addr x%0dy%0d stage%0d", px, py, ps), 32'(mem_addr), r*W + c);
    end
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a frame discards it and clears the outputs
    randomImage();
    runPixels(10);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("midreset rv_after", 32'(result_valid), 0);
    runFrame("post_reset");

    // All-zero image: first pixel holds the maximum of 0
    clearImage();
    runFrame("zero");
    checkOutput("zero exact_x", 32'(max_x), 1);
    checkOutput("zero exact_y", 32'(max_y), 1);

    // Flat 255 interior with a zero border
    clearImage();
    for (int rr = 1; rr <= 8; rr++)
      for (int cc = 1; cc <= 8; cc++) img[rr*W+cc] = 255;
    runFrame("flat255");
    checkOutput("flat255 exact_edge", 32'(edge_cnt), 28);
    checkOutput("flat255 exact_max", 32'(max_grad), 510);

    // Random images
    for (int f = 0; f < 4; f++) begin
      randomImage();
      runFrame($sformatf("random%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
